dm_dmi_slave: RTL
=================

DM_DMI_SLAVE -- requirements
Module: dm_dmi_slave

Interface
REQ-001 SHALL have parameter DMI_WIDTH, default `DMI_WIDTH (40): request/response word {addr[39:34], data[33:2], op[1:0]}.
REQ-002 SHALL have port clk  in  1  single block clock, rising edge.
REQ-003 SHALL have port i_rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports i_dmi_req_vld in 1, i_dmi_req_data in DMI_WIDTH, o_dmi_req_rdy out 1: request channel from the DTM.
REQ-005 SHALL have ports o_dmi_resp_vld out 1, o_dmi_resp_data out DMI_WIDTH, i_dmi_resp_rdy in 1: response channel to the DTM.
REQ-006 SHALL have ports o_dbg_halt_req out 1 and o_dbg_reset_req out 1: hart halt request and ndmreset.
REQ-007 SHALL have port i_dbg_halted  in  1: hart halted status.
REQ-008 SHALL have ports o_dbg_reg_we out 1, o_dbg_reg_addr out 5, o_dbg_reg_wdata out 32, i_dbg_reg_rdata in 32: GPR access; rdata combinational from addr.

Function
REQ-009 SHALL use FSM IDLE -> EXEC -> RESP -> IDLE. o_dmi_req_rdy=1 only in IDLE. A handshake (vld&rdy) latches the request.
REQ-010 SHALL go IDLE->EXEC on handshake, EXEC->RESP after one cycle, and RESP->IDLE on i_dmi_resp_rdy. o_dmi_resp_vld=1 only in RESP. Data stays stable until accepted.
REQ-011 SHALL make o_dmi_resp_vld rise 2 cycles after the request handshake, with no ready stall.
REQ-012 SHALL form the response as {req addr, rdata, resp_op}. resp_op: 0 success; 2 failed for op=3. op=0 (nop) -> success, data 0, no side effect.
REQ-013 SHALL implement the registers below. Any other address reads 0 with success; writes to it are ignored.
- data0 0x04: R/W.
- dmcontrol 0x10: bit31 haltreq, bit1 ndmreset, bit0 dmactive.
- dmstatus 0x11: RO. bits 11/10 = !halted, bits 9/8 = halted, bit7 = 1, [3:0] = 2.
- abstractcs 0x16: [28:24]=0, bit12 busy, [10:8] cmderr (W1C), [3:0]=1.
- command 0x17: write-only, read 0.
REQ-014 SHALL, on a dmcontrol write with dmactive=0, clear haltreq, ndmreset, data0 and cmderr.
REQ-015 SHALL drive o_dbg_halt_req = haltreq and o_dbg_reset_req = ndmreset directly from flops.
REQ-016 SHALL check a command write in this priority, each failure setting cmderr only if cmderr==0:
- cmdtype[31:24] != 0 -> cmderr=2.
- aarsize[22:20] != 2 -> cmderr=2.
- transfer bit17=1 and regno[15:0] outside 0x1000-0x101F -> cmderr=3.
- !i_dbg_halted -> cmderr=4.
- cmderr != 0 already -> command ignored.
REQ-017 SHALL execute a valid command with transfer=1 in EXEC (busy=1 for that cycle):
- o_dbg_reg_addr = regno[4:0].
- write bit16=1: o_dbg_reg_we=1 for exactly one cycle, wdata = data0.
- write bit16=0: data0 <= i_dbg_reg_rdata.
REQ-018 SHALL treat transfer=0 as a successful no-op with no GPR access.
REQ-019 SHALL always return success resp_op for command and abstractcs accesses; errors are reported only via cmderr.

Reset
REQ-020 SHALL, while i_rst is asserted, force the FSM to IDLE and all registers to 0.
REQ-021 SHALL hold outputs at 0 during reset (o_dmi_req_rdy=0, resp_vld=0, resp_data=0, halt/reset req=0, reg_we=0, addr=0, wdata=0), with rdy=1 from the first cycle after deassertion.
REQ-022 SHALL drop a transaction interrupted by reset mid-RESP; no response is replayed.

Structure
REQ-023 SHALL place DMI field widths, register addresses, op/resp codes and cmderr codes in a shared defines header alongside `DMI_WIDTH.
REQ-024 SHALL contain one sub-module, dm_abstract_cmd, holding the command decode/cmderr logic and the GPR port; FSM and CSRs stay in the top.
REQ-025 SHALL stay in a single clock domain; CDC to the DTM uses existing full_handshake_rx/tx at integration level.

Verification
REQ-026 Write addr 0x04 data 0xDEADBEEF op 2, then read 0x04 -> resp data 0xDEADBEEF, op 0; resp_vld 2 cycles after each handshake.
REQ-027 Halted=1, data0=0x12345678, command 0x00231005 -> reg_we one cycle, addr 5, wdata 0x12345678. Command 0x00221005 with rdata 0xCAFE -> data0 reads 0xCAFE.
REQ-028 Halted=0, command 0x00221001 -> abstractcs[10:8]=4, no reg_we. Write abstractcs 0x700 -> cmderr=0.
REQ-029 Command 0x00321001 -> cmderr=2. Following valid command -> ignored, cmderr stays 2.
REQ-030 Write dmcontrol 0x80000003 -> halt_req=1, reset_req=1. Write 0x0 -> both 0, data0 cleared.
REQ-031 Hold resp_rdy=0 for 5 cycles -> resp stable, req_rdy=0. Assert i_rst in RESP -> all outputs 0, next request serviced normally.

Source files
------------

// File: rtl/dm_dmi_slave_pkg.sv
// Shared DMI field layout, debug-module register map, op/response codes and cmderr codes.
// Also supplies the DMI word width default used by the top-level parameter.
`ifndef DMI_WIDTH
`define DMI_WIDTH 40
`endif

package dm_dmi_slave_pkg;

  // DMI word layout: {addr[39:34], data[33:2], op[1:0]}
  localparam int unsigned DmiAddrW   = 6;
  localparam int unsigned DmiDataW   = 32;
  localparam int unsigned DmiOpW     = 2;
  localparam int unsigned DmiOpLsb   = 0;
  localparam int unsigned DmiDataLsb = 2;
  localparam int unsigned DmiAddrLsb = 34;

  localparam logic [1:0] DmiOpNop   = 2'd0;
  localparam logic [1:0] DmiOpRead  = 2'd1;
  localparam logic [1:0] DmiOpWrite = 2'd2;
  localparam logic [1:0] DmiOpRsvd  = 2'd3;

  localparam logic [1:0] DmiRespSuccess = 2'd0;
  localparam logic [1:0] DmiRespFailed  = 2'd2;

  localparam logic [5:0] AddrData0      = 6'h04;
  localparam logic [5:0] AddrDmcontrol  = 6'h10;
  localparam logic [5:0] AddrDmstatus   = 6'h11;
  localparam logic [5:0] AddrAbstractcs = 6'h16;
  localparam logic [5:0] AddrCommand    = 6'h17;

  localparam logic [2:0] CmdErrNone      = 3'd0;
  localparam logic [2:0] CmdErrNotSup    = 3'd2;
  localparam logic [2:0] CmdErrException = 3'd3;
  localparam logic [2:0] CmdErrHaltResume = 3'd4;

  localparam logic [2:0] AarSize32 = 3'd2;

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } dm_state_e;

  // Abstract register numbers 0x1000-0x101F map onto the 32 GPRs.
  function automatic logic regno_is_gpr(input logic [15:0] regno);
    return (regno >= 16'h1000) && (regno <= 16'h101F);
  endfunction

endpackage

// File: rtl/dm_abstract_cmd.sv
// Abstract command decode, cmderr tracking and the GPR access port.
// A command is checked and, if legal, executed in the single cycle cmd_we is high.
module dm_abstract_cmd
  import dm_dmi_slave_pkg::*;
(
  input  logic        clk,
  input  logic        i_rst,
  input  logic        cmd_we,
  input  logic [31:0] cmd,
  input  logic        acs_we,
  input  logic [2:0]  acs_w1c,
  input  logic        clear,
  input  logic        halted,
  input  logic [31:0] data0,
  input  logic [31:0] reg_rdata,
  output logic [2:0]  cmderr,
  output logic        busy,
  output logic        reg_we,
  output logic [4:0]  reg_addr,
  output logic [31:0] reg_wdata,
  output logic        data0_we,
  output logic [31:0] data0_wdata
);

  logic [7:0]  cmdtype;
  logic [2:0]  aarsize;
  logic        transfer;
  logic        write;
  logic [15:0] regno;
  logic [2:0]  err_code;
  logic        exec;
  logic        gpr_access;
  logic [2:0]  cmderr_q, cmderr_d;
  logic        unused_cmd_bits;

  assign cmdtype  = cmd[31:24];
  assign aarsize  = cmd[22:20];
  assign transfer = cmd[17];
  assign write    = cmd[16];
  assign regno    = cmd[15:0];

  assign unused_cmd_bits = ^{cmd[23], cmd[19:18]};

  always_comb begin
    err_code = CmdErrNone;
    if (cmdtype != 8'd0) begin
      err_code = CmdErrNotSup;
    end else if (aarsize != AarSize32) begin
      err_code = CmdErrNotSup;
    end else if (transfer && !regno_is_gpr(regno)) begin
      err_code = CmdErrException;
    end else if (!halted) begin
      err_code = CmdErrHaltResume;
    end
  end

  // A pending error blocks every later command until software clears it.
  assign exec       = cmd_we && (cmderr_q == CmdErrNone) && (err_code == CmdErrNone);
  assign gpr_access = exec && transfer;

  always_comb begin
    busy        = exec;
    reg_we      = gpr_access && write;
    reg_addr    = gpr_access ? regno[4:0] : 5'd0;
    reg_wdata   = (gpr_access && write) ? data0 : 32'd0;
    data0_we    = gpr_access && !write;
    data0_wdata = reg_rdata;
  end

  always_comb begin
    cmderr_d = cmderr_q;
    if (clear) begin
      cmderr_d = CmdErrNone;
    end else if (acs_we) begin
      cmderr_d = cmderr_q & ~acs_w1c;
    end else if (cmd_we && (cmderr_q == CmdErrNone) && (err_code != CmdErrNone)) begin
      cmderr_d = err_code;
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      cmderr_q <= CmdErrNone;
    end else begin
      cmderr_q <= cmderr_d;
    end
  end

  assign cmderr = cmderr_q;

endmodule

// File: rtl/dm_dmi_slave.sv
// Minimal RISC-V debug module DMI slave: one DMI transaction at a time through IDLE/EXEC/RESP,
// hosting data0, dmcontrol, dmstatus, abstractcs and the abstract command register.
`ifndef DMI_WIDTH
`define DMI_WIDTH 40
`endif

module dm_dmi_slave
  import dm_dmi_slave_pkg::*;
#(
  parameter int unsigned DMI_WIDTH = `DMI_WIDTH
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic                 i_dmi_req_vld,
  input  logic [DMI_WIDTH-1:0] i_dmi_req_data,
  output logic                 o_dmi_req_rdy,
  output logic                 o_dmi_resp_vld,
  output logic [DMI_WIDTH-1:0] o_dmi_resp_data,
  input  logic                 i_dmi_resp_rdy,
  output logic                 o_dbg_halt_req,
  output logic                 o_dbg_reset_req,
  input  logic                 i_dbg_halted,
  output logic                 o_dbg_reg_we,
  output logic [4:0]           o_dbg_reg_addr,
  output logic [31:0]          o_dbg_reg_wdata,
  input  logic [31:0]          i_dbg_reg_rdata
);

  dm_state_e state_q, state_d;

  logic [DMI_WIDTH-1:0] req_q;
  logic [DMI_WIDTH-1:0] resp_q, resp_d;
  logic [31:0]          data0_q;
  logic                 haltreq_q;
  logic                 ndmreset_q;
  logic                 dmactive_q;

  logic [DmiAddrW-1:0] req_addr;
  logic [DmiDataW-1:0] req_data;
  logic [DmiOpW-1:0]   req_op;
  logic                in_exec;
  logic                wr_exec;
  logic                dmc_we;
  logic                dmc_clear;
  logic                data0_csr_we;
  logic                cmd_we;
  logic                acs_we;
  logic [31:0]         rdata;

  logic [2:0]  cmderr;
  logic        busy;
  logic        cmd_data0_we;
  logic [31:0] cmd_data0_wdata;

  assign req_addr = req_q[DmiAddrLsb +: DmiAddrW];
  assign req_data = req_q[DmiDataLsb +: DmiDataW];
  assign req_op   = req_q[DmiOpLsb +: DmiOpW];

  assign in_exec      = (state_q == StExec);
  assign wr_exec      = in_exec && (req_op == DmiOpWrite);
  assign dmc_we       = wr_exec && (req_addr == AddrDmcontrol);
  assign dmc_clear    = dmc_we && !req_data[0];
  assign data0_csr_we = wr_exec && (req_addr == AddrData0);
  assign cmd_we       = wr_exec && (req_addr == AddrCommand);
  assign acs_we       = wr_exec && (req_addr == AddrAbstractcs);

  always_comb begin
    state_d        = state_q;
    o_dmi_req_rdy  = 1'b0;
    o_dmi_resp_vld = 1'b0;
    case (state_q)
      StIdle: begin
        o_dmi_req_rdy = ~i_rst;
        if (i_dmi_req_vld) begin
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StResp;
      end
      StResp: begin
        o_dmi_resp_vld = 1'b1;
        if (i_dmi_resp_rdy) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Register read view, sampled in EXEC before any write of the same transaction lands.
  always_comb begin
    rdata = 32'd0;
    case (req_addr)
      AddrData0:      rdata = data0_q;
      AddrDmcontrol:  rdata = {haltreq_q, 29'd0, ndmreset_q, dmactive_q};
      AddrDmstatus:   rdata = {20'd0, ~i_dbg_halted, ~i_dbg_halted, i_dbg_halted, i_dbg_halted,
                               1'b1, 3'd0, 4'd2};
      AddrAbstractcs: rdata = {3'd0, 5'd0, 11'd0, busy, 1'b0, cmderr, 4'd0, 4'd1};
      default:        rdata = 32'd0;
    endcase
  end

  always_comb begin
    resp_d = '0;
    resp_d[DmiAddrLsb +: DmiAddrW] = req_addr;
    resp_d[DmiDataLsb +: DmiDataW] = (req_op == DmiOpRead) ? rdata : 32'd0;
    resp_d[DmiOpLsb +: DmiOpW]     = (req_op == DmiOpRsvd) ? DmiRespFailed : DmiRespSuccess;
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      resp_q  <= '0;
    end else begin
      state_q <= state_d;
      if ((state_q == StIdle) && i_dmi_req_vld) begin
        req_q <= i_dmi_req_data;
      end
      if (in_exec) begin
        resp_q <= resp_d;
      end
    end
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      data0_q    <= 32'd0;
      haltreq_q  <= 1'b0;
      ndmreset_q <= 1'b0;
      dmactive_q <= 1'b0;
    end else begin
      if (dmc_we) begin
        dmactive_q <= req_data[0];
        haltreq_q  <= req_data[0] & req_data[31];
        ndmreset_q <= req_data[0] & req_data[1];
      end
      if (dmc_clear) begin
        data0_q <= 32'd0;
      end else if (data0_csr_we) begin
        data0_q <= req_data;
      end else if (cmd_data0_we) begin
        data0_q <= cmd_data0_wdata;
      end
    end
  end

  dm_abstract_cmd u_abstract_cmd (
    .clk         (clk),
    .i_rst       (i_rst),
    .cmd_we      (cmd_we),
    .cmd         (req_data),
    .acs_we      (acs_we),
    .acs_w1c     (req_data[10:8]),
    .clear       (dmc_clear),
    .halted      (i_dbg_halted),
    .data0       (data0_q),
    .reg_rdata   (i_dbg_reg_rdata),
    .cmderr      (cmderr),
    .busy        (busy),
    .reg_we      (o_dbg_reg_we),
    .reg_addr    (o_dbg_reg_addr),
    .reg_wdata   (o_dbg_reg_wdata),
    .data0_we    (cmd_data0_we),
    .data0_wdata (cmd_data0_wdata)
  );

  assign o_dmi_resp_data = resp_q;
  assign o_dbg_halt_req  = haltreq_q;
  assign o_dbg_reset_req = ndmreset_q;

endmodule
